// File: rtl/ddc_out_pkg.sv
// rtl/ddc_out_pkg.sv - shared types and width-derived constants for the DDC output serializer
//
// Contents:
//   out_state_e  : output FSM states (IDLE, SEND_I, SEND_Q)
//   iq_pair_t    : FIFO entry layout {I, Q} at the default output width
//   round_const  : rounding offset, 1 << (in_w - out_w - 1)
//   sat_max      : largest positive out_w-bit two's complement value
package ddc_out_pkg;

  localparam int DEF_FILTER_W = 18;
  localparam int DEF_OUT_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_I = 2'd1,
    SEND_Q = 2'd2
  } out_state_e;

  // I occupies the upper half of a packed entry, Q the lower half.
  typedef struct packed {
    logic [DEF_OUT_W-1:0] i;
    logic [DEF_OUT_W-1:0] q;
  } iq_pair_t;

  function automatic logic [31:0] round_const(input int in_w, input int out_w);
    return 32'd1 << (in_w - out_w - 1);
  endfunction

  function automatic logic [31:0] sat_max(input int out_w);
    return (32'd1 << (out_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/ddc_out_fifo.sv
// rtl/ddc_out_fifo.sv - synchronous pointer FIFO holding packed I/Q pairs
//
// Ports:
//   clk, rst_param : clock, asynchronous active-low reset
//   wr_en, wr_data : write request and entry
//   rd_en          : pop the head entry (ignored when empty)
//   rd_data        : current head entry
//   empty          : no entries stored
//   level          : entries stored, 0 .. 2^AW
//   drop           : write request refused because full with no pop
module ddc_out_fifo #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_param,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          drop
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign rd_ok = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write on full is still taken.
  assign wr_ok = wr_en && (!full || rd_ok);
  assign drop  = wr_en && !wr_ok;

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end

  always_ff @(posedge clk or negedge rst_param) begin
    if (!rst_param) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/ddc_out_serializer.sv
// rtl/ddc_out_serializer.sv - pairs I/Q samples, rounds/saturates, buffers and serializes I then Q
//
// Optional build macro DDC_OUT_TEST_PATTERN_EN adds input test_mode, which replaces
// each completed pair with an internal counter (I = cnt, Q = ~cnt).
//
// Ports:
//   clk, rst_param     : clock, asynchronous active-low reset
//   out_enable         : allows the output FSM to start a pair
//   clr_status         : clears fifo_ovf and pair_err (a coincident set wins)
//   i_data, i_flag     : I sample and strobe
//   q_data, q_flag     : Q sample and strobe
//   dout, dout_valid   : serialized sample and qualifier
//   dout_iq            : 0 = I beat, 1 = Q beat
//   fifo_level         : pairs stored
//   fifo_ovf, pair_err : sticky error flags
module ddc_out_serializer
  import ddc_out_pkg::*;
#(
  parameter int FILTERBITWIDTH = 18,
  parameter int OUTBITWIDTH    = 16,
  parameter int FIFO_AW        = 2
) (
  input  logic                      clk,
  input  logic                      rst_param,
  input  logic                      out_enable,
  input  logic                      clr_status,
`ifdef DDC_OUT_TEST_PATTERN_EN
  input  logic                      test_mode,
`endif
  input  logic [FILTERBITWIDTH-1:0] i_data,
  input  logic                      i_flag,
  input  logic [FILTERBITWIDTH-1:0] q_data,
  input  logic                      q_flag,
  output logic [OUTBITWIDTH-1:0]    dout,
  output logic                      dout_valid,
  output logic                      dout_iq,
  output logic [FIFO_AW:0]          fifo_level,
  output logic                      fifo_ovf,
  output logic                      pair_err
);

  localparam int FW = FILTERBITWIDTH;
  localparam int OW = OUTBITWIDTH;
  localparam logic [FW:0]   RND_CONST = (FW+1)'(round_const(FW, OW));
  localparam logic [OW-1:0] SAT_MAX   = OW'(sat_max(OW));

  // Sign-extend by one bit so the rounding add cannot wrap; only a positive
  // input can carry into the sign position, which is what gets saturated.
  function automatic logic [OW-1:0] round_sat(input logic [FW-1:0] x);
    logic [FW:0] sum;
    sum = {x[FW-1], x} + RND_CONST;
    if (!sum[FW] && sum[FW-1]) begin
      return SAT_MAX;
    end
    return OW'(sum >> (FW - OW));
  endfunction

  // Pairing, rounding stage and sticky flags
  logic [FW-1:0] hold_i_q, hold_i_d;
  logic [FW-1:0] hold_q_q, hold_q_d;
  logic          hold_i_vld_q, hold_i_vld_d;
  logic          hold_q_vld_q, hold_q_vld_d;
  logic [OW-1:0] rnd_i_q, rnd_i_d;
  logic [OW-1:0] rnd_q_q, rnd_q_d;
  logic          rnd_vld_q, rnd_vld_d;
  logic          fifo_ovf_q, fifo_ovf_d;
  logic          pair_err_q, pair_err_d;
  logic          pair_done;
  logic          pair_err_set;
  logic [OW-1:0] sel_i;
  logic [OW-1:0] sel_q;

  logic              fifo_rd;
  logic [2*OW-1:0]   fifo_head;
  logic              fifo_empty;
  logic              fifo_drop;
  logic [FIFO_AW:0]  fifo_level_w;

  assign pair_done = hold_i_vld_q && hold_q_vld_q;

  // A repeat strobe before the partner arrives loses the earlier sample.
  assign pair_err_set = (i_flag && hold_i_vld_q && !hold_q_vld_q) ||
                        (q_flag && hold_q_vld_q && !hold_i_vld_q);

`ifdef DDC_OUT_TEST_PATTERN_EN
  logic [OW-1:0] tp_cnt_q, tp_cnt_d;

  always_comb begin
    tp_cnt_d = pair_done ? tp_cnt_q + 1'b1 : tp_cnt_q;
    sel_i    = test_mode ? tp_cnt_q  : round_sat(hold_i_q);
    sel_q    = test_mode ? ~tp_cnt_q : round_sat(hold_q_q);
  end

  always_ff @(posedge clk or negedge rst_param) begin
    if (!rst_param) begin
      tp_cnt_q <= '0;
    end else begin
      tp_cnt_q <= tp_cnt_d;
    end
  end
`else
  always_comb begin
    sel_i = round_sat(hold_i_q);
    sel_q = round_sat(hold_q_q);
  end
`endif

  always_comb begin
    hold_i_d     = i_flag ? i_data : hold_i_q;
    hold_q_d     = q_flag ? q_data : hold_q_q;
    // A strobe landing in the completion cycle starts the next pair.
    hold_i_vld_d = i_flag || (hold_i_vld_q && !pair_done);
    hold_q_vld_d = q_flag || (hold_q_vld_q && !pair_done);
    rnd_vld_d    = pair_done;
    rnd_i_d      = pair_done ? sel_i : rnd_i_q;
    rnd_q_d      = pair_done ? sel_q : rnd_q_q;
    fifo_ovf_d   = fifo_drop    ? 1'b1 : (clr_status ? 1'b0 : fifo_ovf_q);
    pair_err_d   = pair_err_set ? 1'b1 : (clr_status ? 1'b0 : pair_err_q);
  end

  always_ff @(posedge clk or negedge rst_param) begin
    if (!rst_param) begin
      hold_i_q     <= '0;
      hold_q_q     <= '0;
      hold_i_vld_q <= 1'b0;
      hold_q_vld_q <= 1'b0;
      rnd_i_q      <= '0;
      rnd_q_q      <= '0;
      rnd_vld_q    <= 1'b0;
      fifo_ovf_q   <= 1'b0;
      pair_err_q   <= 1'b0;
    end else begin
      hold_i_q     <= hold_i_d;
      hold_q_q     <= hold_q_d;
      hold_i_vld_q <= hold_i_vld_d;
      hold_q_vld_q <= hold_q_vld_d;
      rnd_i_q      <= rnd_i_d;
      rnd_q_q      <= rnd_q_d;
      rnd_vld_q    <= rnd_vld_d;
      fifo_ovf_q   <= fifo_ovf_d;
      pair_err_q   <= pair_err_d;
    end
  end

  ddc_out_fifo #(
    .DW (2*OW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst_param (rst_param),
    .wr_en     (rnd_vld_q),
    .wr_data   ({rnd_i_q, rnd_q_q}),
    .rd_en     (fifo_rd),
    .rd_data   (fifo_head),
    .empty     (fifo_empty),
    .level     (fifo_level_w),
    .drop      (fifo_drop)
  );

  // Output FSM
  out_state_e state_q, state_d;
  logic       dout_valid_q, dout_valid_d;
  logic       dout_iq_q, dout_iq_d;

  always_comb begin
    state_d = state_q;
    fifo_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && out_enable) begin
          state_d = SEND_I;
        end
      end
      SEND_I: begin
        state_d = SEND_Q;
      end
      SEND_Q: begin
        fifo_rd = 1'b1;
        // Occupancy after this pop, counting a write landing in the same cycle.
        if (((fifo_level_w > (FIFO_AW+1)'(1)) || rnd_vld_q) && out_enable) begin
          state_d = SEND_I;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    dout_valid_d = (state_d != IDLE);
    dout_iq_d    = (state_d == SEND_Q);
  end

  always_ff @(posedge clk or negedge rst_param) begin
    if (!rst_param) begin
      state_q      <= IDLE;
      dout_valid_q <= 1'b0;
      dout_iq_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_valid_q <= dout_valid_d;
      dout_iq_q    <= dout_iq_d;
    end
  end

  // The head entry stays put until the SEND_Q pop, so both beats read it directly.
  always_comb begin
    dout = '0;
    if (dout_valid_q) begin
      dout = dout_iq_q ? fifo_head[OW-1:0] : fifo_head[2*OW-1:OW];
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_iq    = dout_iq_q;
  assign fifo_level = fifo_level_w;
  assign fifo_ovf   = fifo_ovf_q;
  assign pair_err   = pair_err_q;

endmodule
